// File: rtl/secuenciador_filtros.sv
// Sequences NB filter bands over one held ADC sample and outputs their saturated sum.
// Optional per-band timeout: define SECUENCIADOR_TIMEOUT_EN.
module secuenciador_filtros #(
    parameter int N  = 25,
    parameter int NB = 3,
    parameter int TO = 16
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Bandera_ADC,
    input  logic [N-1:0]    Uk,
    output logic [N-1:0]    Uk_Filtro,
    output logic [NB-1:0]   Inicio_Filtro,
    input  logic [NB*N-1:0] Yk_Filtro,
    input  logic [NB-1:0]   Listo_Filtro,
    output logic [N-1:0]    Yk,
    output logic            Bandera_Listo,
    output logic            Ocupado,
    output logic            Muestra_Perdida,
    output logic            Error_Timeout
);
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = N + 2;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LANZAR   = 3'd1;
    localparam logic [2:0] ESPERAR  = 3'd2;
    localparam logic [2:0] ACUMULAR = 3'd3;
    localparam logic [2:0] SALIDA   = 3'd4;

    localparam logic [AW-1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};
    localparam logic [KW-1:0] K_LAST  = KW'(NB - 1);

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [N-1:0]  uk_q, uk_d;
    logic [N-1:0]  yk_q, yk_d;
    logic [N-1:0]  band_y;
    logic [AW-1:0] band_ext;
    logic [N-1:0]  sat_val;
    logic          listo_k;
    logic          skip_band;

    assign band_y   = Yk_Filtro[k_q*N +: N];
    assign band_ext = {{2{band_y[N-1]}}, band_y};
    assign listo_k  = Listo_Filtro[k_q];

    always_comb begin
        if ($signed(acc_q) > $signed(SAT_MAX))      sat_val = SAT_MAX[N-1:0];
        else if ($signed(acc_q) < $signed(SAT_MIN)) sat_val = SAT_MIN[N-1:0];
        else                                        sat_val = acc_q[N-1:0];
    end

`ifdef SECUENCIADOR_TIMEOUT_EN
    localparam int CW = $clog2(TO + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          err_q, err_d;

    assign skip_band     = tmo_q;
    assign Error_Timeout = err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    // TO only has meaning in the timeout build.
    localparam int Timeout_unused = TO;
    assign skip_band     = 1'b0;
    assign Error_Timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        uk_d    = uk_q;
        yk_d    = yk_q;
`ifdef SECUENCIADOR_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (Bandera_ADC) begin
                    uk_d    = Uk;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = LANZAR;
                end
            end
            LANZAR: begin
                state_d = ESPERAR;
`ifdef SECUENCIADOR_TIMEOUT_EN
                cnt_d   = '0;
                tmo_d   = 1'b0;
`endif
            end
            ESPERAR: begin
                if (listo_k) begin
                    state_d = ACUMULAR;
                end
`ifdef SECUENCIADOR_TIMEOUT_EN
                // A silent band contributes 0 and the sequence carries on.
                else if (cnt_q == CW'(TO - 1)) begin
                    state_d = ACUMULAR;
                    tmo_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ACUMULAR: begin
                acc_d = acc_q + (skip_band ? {AW{1'b0}} : band_ext);
                if (k_q == K_LAST) begin
                    state_d = SALIDA;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = LANZAR;
                end
            end
            SALIDA: begin
                yk_d    = sat_val;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            uk_q    <= '0;
            yk_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            uk_q    <= uk_d;
            yk_q    <= yk_d;
        end
    end

    always_comb begin
        Inicio_Filtro = '0;
        if (state_q == LANZAR) Inicio_Filtro[k_q] = 1'b1;
    end

    // The new result is visible during the SALIDA pulse itself, then held.
    assign Yk              = (state_q == SALIDA) ? sat_val : yk_q;
    assign Uk_Filtro       = uk_q;
    assign Bandera_Listo   = (state_q == SALIDA);
    assign Ocupado         = (state_q != IDLE);
    assign Muestra_Perdida = Bandera_ADC && (state_q != IDLE);

endmodule

// File: tb/tb_secuenciador_filtros.sv
// Bench for secuenciador_filtros: band models with latency L, reference sum with clamping.
`timescale 1ns/1ps
module tb_secuenciador_filtros;
    localparam int N  = 25;
    localparam int NB = 3;
    localparam int TO = 16;

    logic                   Clk = 1'b0;
    logic                   Rst_n = 1'b0;
    logic                   Bandera_ADC = 1'b0;
    logic [N-1:0]           Uk = '0;
    logic [N-1:0]           Uk_Filtro, Yk;
    logic [NB-1:0]          Inicio_Filtro, Listo_Filtro;
    logic [NB-1:0]          listo_model = '0, listo_force = '0, never_mask = '0;
    logic [NB-1:0][N-1:0]   band_val = '0;
    logic [NB*N-1:0]        Yk_Filtro;
    logic                   Bandera_Listo, Ocupado, Muestra_Perdida, Error_Timeout;

    int errors = 0, checks = 0;
    int cyc = 0;
    int band_lat = 10;
    int stray_lo = 1000000, stray_hi = 0;
    int start_cyc [NB];
    logic [NB-1:0] armed = '0;
    int starts_q[$];

    assign Yk_Filtro    = band_val;
    assign Listo_Filtro = listo_model | listo_force;

    secuenciador_filtros #(.N(N), .NB(NB), .TO(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Bandera_ADC(Bandera_ADC), .Uk(Uk),
        .Uk_Filtro(Uk_Filtro), .Inicio_Filtro(Inicio_Filtro), .Yk_Filtro(Yk_Filtro),
        .Listo_Filtro(Listo_Filtro), .Yk(Yk), .Bandera_Listo(Bandera_Listo),
        .Ocupado(Ocupado), .Muestra_Perdida(Muestra_Perdida), .Error_Timeout(Error_Timeout)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Band k raises Listo exactly band_lat cycles after the cycle its start pulse is seen.
    always @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            armed       = '0;
            listo_model = '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                listo_model[k] = 1'b0;
                if (Inicio_Filtro[k]) begin
                    armed[k]     = 1'b1;
                    start_cyc[k] = cyc;
                end else if (armed[k] && !never_mask[k] && (cyc - start_cyc[k] == band_lat)) begin
                    listo_model[k] = 1'b1;
                    armed[k]       = 1'b0;
                end
            end
            listo_force    = '0;
            listo_force[2] = (cyc >= stray_lo) && (cyc <= stray_hi);
        end
    end

    function automatic logic [N-1:0] ref_yk(input logic [NB-1:0][N-1:0] v, input logic [NB-1:0] skip);
        longint s, mx, mn;
        logic [63:0] t;
        s  = 0;
        mx = (longint'(1) << (N-1)) - 1;
        mn = -(longint'(1) << (N-1));
        for (int k = 0; k < NB; k++) if (!skip[k]) s += longint'($signed(v[k]));
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        t = s;
        return t[N-1:0];
    endfunction

    // Cycle n = n rising edges after the edge that sampled the strobe.
    task automatic do_sample(input logic [N-1:0] u, input int budget, input int inj_cyc,
                             input logic [N-1:0] inj_val, output int lat,
                             output logic [N-1:0] y, output int drops);
        starts_q.delete();
        lat = -1; y = '0; drops = 0;
        @(negedge Clk); Bandera_ADC = 1'b1; Uk = u;
        @(posedge Clk);
        for (int n = 1; n <= budget; n++) begin
            @(negedge Clk);
            if (n == inj_cyc) begin Bandera_ADC = 1'b1; Uk = inj_val; end
            else Bandera_ADC = 1'b0;
            #1;
            if (Muestra_Perdida) drops++;
            for (int k = 0; k < NB; k++) if (Inicio_Filtro[k]) starts_q.push_back(k);
            if (Bandera_Listo) begin lat = n; y = Yk; break; end
        end
        @(negedge Clk); Bandera_ADC = 1'b0;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if ({Uk_Filtro, Yk, Inicio_Filtro, Bandera_Listo, Ocupado, Muestra_Perdida, Error_Timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got Ukf=%0h Yk=%0h Ini=%0b BL=%0b Oc=%0b MP=%0b ET=%0b, required all 0",
                     Uk_Filtro, Yk, Inicio_Filtro, Bandera_Listo, Ocupado, Muestra_Perdida, Error_Timeout);
        end
        @(negedge Clk); Rst_n = 1'b1;
    endtask

    task automatic test_single_sample;
        int lat, drops; logic [N-1:0] y, u; bit order_ok;
        band_lat = 10;
        band_val[0] = N'(100); band_val[1] = N'(-30); band_val[2] = N'(5);
        u = N'($urandom());
        do_sample(u, 200, 0, '0, lat, y, drops);
        checks++; if (lat !== 37) begin errors++; $display("FAIL single_latency: got %0d required 37", lat); end
        checks++; if (y !== N'(75)) begin errors++; $display("FAIL single_yk: got %0d required 75", $signed(y)); end
        order_ok = (starts_q.size() == NB);
        if (order_ok) for (int k = 0; k < NB; k++) if (starts_q[k] != k) order_ok = 0;
        checks++; if (!order_ok) begin errors++; $display("FAIL single_start_order: got %p required 0,1,2", starts_q); end
        checks++; if (drops !== 0) begin errors++; $display("FAIL single_no_drop: got %0d required 0", drops); end
        repeat (5) @(negedge Clk);
        #1;
        checks++; if (Yk !== N'(75)) begin errors++; $display("FAIL single_yk_hold: got %0h required %0h", Yk, N'(75)); end
        checks++; if (Uk_Filtro !== u) begin errors++; $display("FAIL single_uk_hold: got %0h required %0h", Uk_Filtro, u); end
        checks++; if (Ocupado !== 1'b0) begin errors++; $display("FAIL single_idle: got Ocupado=%0b required 0", Ocupado); end
    endtask

    task automatic test_saturation;
        int lat, drops; logic [N-1:0] y;
        band_lat = 3;
        band_val[0] = 25'h0FFFFFF; band_val[1] = 25'h0000010; band_val[2] = '0;
        do_sample(N'($urandom()), 100, 0, '0, lat, y, drops);
        checks++; if (y !== 25'h0FFFFFF) begin errors++; $display("FAIL sat_pos: got %0h required 0FFFFFF", y); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL sat_latency: got %0d required 16", lat); end
        band_val[0] = 25'h1000000; band_val[1] = 25'h1FFFFFF; band_val[2] = '0;
        do_sample(N'($urandom()), 100, 0, '0, lat, y, drops);
        checks++; if (y !== 25'h1000000) begin errors++; $display("FAIL sat_neg: got %0h required 1000000", y); end
    endtask

    task automatic test_random;
        int lat, drops, exp_lat; logic [N-1:0] y, u, e;
        for (int it = 0; it < 8; it++) begin
            band_lat = $urandom_range(1, 6);
            for (int k = 0; k < NB; k++) begin
                case ($urandom_range(0, 3))
                    0:       band_val[k] = 25'h0FFFFFF;
                    1:       band_val[k] = 25'h1000000;
                    default: band_val[k] = N'($urandom());
                endcase
            end
            u = N'($urandom());
            e = ref_yk(band_val, '0);
            exp_lat = NB * (band_lat + 2) + 1;
            do_sample(u, 200, 0, '0, lat, y, drops);
            checks++; if (y !== e) begin errors++; $display("FAIL random_yk[%0d]: got %0h required %0h", it, y, e); end
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL random_latency[%0d]: got %0d required %0d", it, lat, exp_lat); end
            checks++; if (Uk_Filtro !== u) begin errors++; $display("FAIL random_uk[%0d]: got %0h required %0h", it, Uk_Filtro, u); end
        end
    endtask

    task automatic test_overrun;
        int lat, drops, extra; logic [N-1:0] y, u;
        band_lat = 10;
        band_val[0] = N'(11); band_val[1] = N'(22); band_val[2] = N'(33);
        u = 25'h0123456;
        do_sample(u, 200, 5, N'(7), lat, y, drops);
        checks++; if (drops !== 1) begin errors++; $display("FAIL overrun_drop_pulses: got %0d required 1", drops); end
        checks++; if (Uk_Filtro !== u) begin errors++; $display("FAIL overrun_uk_kept: got %0h required %0h", Uk_Filtro, u); end
        checks++; if (y !== N'(66) || lat !== 37) begin errors++; $display("FAIL overrun_result: got yk=%0d lat=%0d required 66 at 37", y, lat); end
        extra = 0;
        repeat (40) begin @(negedge Clk); #1; if (Bandera_Listo) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL overrun_single_listo: got %0d extra pulses required 0", extra); end
    endtask

    task automatic test_salida_edge;
        logic [N-1:0] e; bit found;
        band_lat = 2;
        band_val[0] = N'(-5); band_val[1] = N'(9); band_val[2] = N'(1);
        e = N'(5);
        @(negedge Clk); Bandera_ADC = 1'b1; Uk = 25'h00000A1;
        @(posedge Clk);
        @(negedge Clk); Bandera_ADC = 1'b0;
        repeat (12) @(negedge Clk);
        Bandera_ADC = 1'b1; Uk = 25'h00000B2;
        #1;
        checks++; if (Bandera_Listo !== 1'b1 || Muestra_Perdida !== 1'b1)
            begin errors++; $display("FAIL salida_drop: got BL=%0b MP=%0b required 1 1", Bandera_Listo, Muestra_Perdida); end
        @(negedge Clk); Uk = 25'h00000C3;
        #1;
        checks++; if (Ocupado !== 1'b0 || Muestra_Perdida !== 1'b0)
            begin errors++; $display("FAIL salida_next_idle: got Oc=%0b MP=%0b required 0 0", Ocupado, Muestra_Perdida); end
        @(negedge Clk); Bandera_ADC = 1'b0;
        #1;
        checks++; if (Ocupado !== 1'b1 || Uk_Filtro !== 25'h00000C3)
            begin errors++; $display("FAIL salida_accept: got Oc=%0b Ukf=%0h required 1 c3", Ocupado, Uk_Filtro); end
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge Clk); #1;
            if (Bandera_Listo) begin
                found = 1;
                checks++; if (Yk !== e) begin errors++; $display("FAIL salida_second_yk: got %0h required %0h", Yk, e); end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL salida_second_done: got no Bandera_Listo required one"); end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid;
        int lat, drops, seen; logic [N-1:0] y;
        band_lat = 10;
        band_val[0] = N'(50); band_val[1] = N'(60); band_val[2] = N'(-10);
        @(negedge Clk); Bandera_ADC = 1'b1; Uk = 25'h0055AA5;
        @(posedge Clk);
        @(negedge Clk); Bandera_ADC = 1'b0;
        repeat (17) @(negedge Clk);
        #1;
        checks++; if (Ocupado !== 1'b1 || Uk_Filtro !== 25'h0055AA5)
            begin errors++; $display("FAIL rstmid_busy: got Oc=%0b Ukf=%0h required 1 55aa5", Ocupado, Uk_Filtro); end
        Rst_n = 1'b0;
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if ({Uk_Filtro, Yk, Inicio_Filtro, Bandera_Listo, Ocupado, Muestra_Perdida, Error_Timeout} !== '0) begin
                errors++;
                $display("FAIL rstmid_outputs[%0d]: got Ukf=%0h Yk=%0h Ini=%0b BL=%0b Oc=%0b required all 0",
                         n, Uk_Filtro, Yk, Inicio_Filtro, Bandera_Listo, Ocupado);
            end
            @(negedge Clk);
        end
        Rst_n = 1'b1;
        repeat (40) begin @(negedge Clk); #1; if (Bandera_Listo || Ocupado) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_aborted: got %0d busy/done cycles required 0", seen); end
        do_sample(N'($urandom()), 200, 0, '0, lat, y, drops);
        checks++; if (y !== N'(100) || lat !== 37) begin errors++; $display("FAIL rstmid_resume: got yk=%0d lat=%0d required 100 at 37", y, lat); end
    endtask

    task automatic test_stray_done;
        int lat, drops; logic [N-1:0] y;
        band_lat = 10;
        band_val[0] = N'(7); band_val[1] = N'(8); band_val[2] = N'(1000);
        stray_lo = cyc + 4; stray_hi = cyc + 8;
        do_sample(N'($urandom()), 200, 0, '0, lat, y, drops);
        stray_lo = 1000000; stray_hi = 0;
        checks++; if (y !== N'(1015)) begin errors++; $display("FAIL stray_yk: got %0d required 1015", y); end
        checks++; if (lat !== 37) begin errors++; $display("FAIL stray_latency: got %0d required 37", lat); end
    endtask

    task automatic test_timeout;
        int lat, drops; logic [N-1:0] y, e;
        band_lat = 4;
        band_val[0] = N'(40); band_val[1] = N'(2); band_val[2] = N'(999);
        never_mask = 3'b100;
`ifdef SECUENCIADOR_TIMEOUT_EN
        do_sample(N'($urandom()), 300, 0, '0, lat, y, drops);
        checks++; if (y !== N'(42)) begin errors++; $display("FAIL timeout_yk: got %0d required 42", y); end
        checks++; if (lat !== 2 * (band_lat + 2) + TO + 2 + 1) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", lat, 2 * (band_lat + 2) + TO + 3); end
        checks++; if (Error_Timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0b required 1", Error_Timeout); end
        never_mask = '0;
        for (int k = 0; k < NB; k++) band_val[k] = N'($urandom());
        e = ref_yk(band_val, '0);
        do_sample(N'($urandom()), 300, 0, '0, lat, y, drops);
        checks++; if (y !== e) begin errors++; $display("FAIL timeout_next_yk: got %0h required %0h", y, e); end
        checks++; if (Error_Timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b required 1", Error_Timeout); end
`else
        do_sample(N'($urandom()), 200, 0, '0, lat, y, drops);
        #1;
        checks++; if (lat !== -1 || Ocupado !== 1'b1) begin errors++; $display("FAIL notimeout_hang: got lat=%0d Oc=%0b required -1 1", lat, Ocupado); end
        checks++; if (Error_Timeout !== 1'b0) begin errors++; $display("FAIL notimeout_flag: got %0b required 0", Error_Timeout); end
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        never_mask = '0;
        e = ref_yk(band_val, '0);
        do_sample(N'($urandom()), 200, 0, '0, lat, y, drops);
        checks++; if (y !== e) begin errors++; $display("FAIL notimeout_recover: got %0h required %0h", y, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_saturation();
        test_random();
        test_overrun();
        test_salida_edge();
        test_reset_mid();
        test_stray_done();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
